// File: rtl/term_pkg.sv
// Shared constants, control codes and state encoding for the
// terminal VRAM writer.
package term_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int COLW = 7;
  localparam int ROWW = 5;
  localparam int AW   = 13;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] ESC   = 8'h1B;

  typedef logic [COLW-1:0] col_t;
  typedef logic [ROWW-1:0] row_t;

  localparam col_t COL_MAX = COLW'(COLS - 1);
  localparam row_t ROW_MAX = ROWW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_CLR_ALL,
    S_CLR_ROW,
    S_IDLE,
    S_ESC,
    S_CSI
  } state_t;

  function automatic logic [AW-1:0] vaddr(row_t r, col_t c);
    return {{(AW-ROWW-COLW){1'b0}}, r, c};
  endfunction

endpackage

// File: rtl/term_vram_writer_if.sv
// Byte stream in, VRAM write port out. master is the writer side,
// slave is the uart/charbuf side.
interface term_vram_writer_if;

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [term_pkg::AW-1:0] vram_addr;
  logic [7:0]             vram_data;
  logic                   vram_we;

  modport master (
    input  in_data, in_valid,
    output in_ready, vram_addr, vram_data, vram_we
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, vram_addr, vram_data, vram_we
  );

endinterface

// File: rtl/term_clear_engine.sv
// Row/col sweep counter for full-screen and single-row clears.
// Comes out of reset armed for a full-screen sweep.
module term_clear_engine
  import term_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic all,
  input  logic step,
  input  row_t row_sel,
  output row_t row,
  output col_t col,
  output logic done
);

  logic all_r;
  logic last;

  assign last = (col == COL_MAX) && (!all_r || row == ROW_MAX);
  assign done = step & last;

  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      all_r <= 1'b1;
    end else if (start) begin
      row   <= all ? '0 : row_sel;
      col   <= '0;
      all_r <= all;
    end else if (step) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (all_r && !last) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/term_vram_writer.sv
// Terminal VRAM write sequencer: cursor, control codes, clears.
// Define TERM_ESC_FILTER_EN to swallow ESC / CSI sequences.
module term_vram_writer
  import term_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  term_vram_writer_if.master bus,
  output col_t               cur_col,
  output row_t               cur_row,
  output logic               busy
);

  state_t          state, state_n;
  col_t            col_n;
  row_t            row_n;
  logic            we_r, we_n;
  logic [AW-1:0]   addr_r, addr_n;
  logic [7:0]      data_r, data_n;
  logic            eng_start, eng_all, eng_step, eng_done;
  row_t            eng_row;
  col_t            eng_col;
  logic            adv, clr_all;
  logic [7:0]      b, tab;
`ifdef TERM_ESC_FILTER_EN
  logic [1:0]      seq, seq_n;
`endif

  term_clear_engine u_clr (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .all     (eng_all),
    .step    (eng_step),
    .row_sel (row_n),
    .row     (eng_row),
    .col     (eng_col),
    .done    (eng_done)
  );

  assign bus.in_ready  = (state == S_IDLE) || (state == S_ESC)
                      || (state == S_CSI);
  assign busy          = (state == S_CLR_ALL) || (state == S_CLR_ROW);
  assign bus.vram_we   = we_r;
  assign bus.vram_addr = addr_r;
  assign bus.vram_data = data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLR_ALL;
      cur_col <= '0;
      cur_row <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      data_r  <= BLANK;
`ifdef TERM_ESC_FILTER_EN
      seq     <= '0;
`endif
    end else begin
      state   <= state_n;
      cur_col <= col_n;
      cur_row <= row_n;
      we_r    <= we_n;
      addr_r  <= addr_n;
      data_r  <= data_n;
`ifdef TERM_ESC_FILTER_EN
      seq     <= seq_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = cur_col;
    row_n     = cur_row;
    we_n      = 1'b0;
    addr_n    = addr_r;
    data_n    = data_r;
    eng_start = 1'b0;
    eng_all   = 1'b0;
    eng_step  = 1'b0;
    adv       = 1'b0;
    clr_all   = 1'b0;
    b         = bus.in_data;
    tab       = ({1'b0, cur_col} | 8'h07) + 8'd1;
`ifdef TERM_ESC_FILTER_EN
    seq_n     = seq;
`endif
    case (state)
      S_CLR_ALL, S_CLR_ROW: begin
        we_n     = 1'b1;
        addr_n   = vaddr(eng_row, eng_col);
        data_n   = BLANK;
        eng_step = 1'b1;
        if (eng_done) state_n = S_IDLE;
      end
      S_IDLE: if (bus.in_valid) begin
        unique case (1'b1)
          (b >= 8'h20 && b <= 8'h7E): begin
            we_n   = 1'b1;
            addr_n = vaddr(cur_row, cur_col);
            data_n = b;
            if (cur_col == COL_MAX) begin
              col_n = '0;
              adv   = 1'b1;
            end else begin
              col_n = cur_col + 1'b1;
            end
          end
          (b == CR): col_n = '0;
          (b == LF): adv = 1'b1;
          (b == BS): if (cur_col != '0) begin
            col_n  = cur_col - 1'b1;
            we_n   = 1'b1;
            addr_n = vaddr(cur_row, col_n);
            data_n = BLANK;
          end
          (b == TAB): col_n = (tab > {1'b0, COL_MAX})
                            ? COL_MAX : tab[COLW-1:0];
          (b == FF): clr_all = 1'b1;
`ifdef TERM_ESC_FILTER_EN
          (b == ESC): state_n = S_ESC;
`endif
          default: ;
        endcase
      end
`ifdef TERM_ESC_FILTER_EN
      S_ESC: if (bus.in_valid) begin
        state_n = (b == 8'h5B) ? S_CSI : S_IDLE;
        seq_n   = '0;
      end
      // seq tracks whether the parameter bytes are exactly "2"
      S_CSI: if (bus.in_valid) begin
        if (b >= 8'h20 && b <= 8'h3F) begin
          seq_n = (seq == 2'd0 && b == 8'h32) ? 2'd1 : 2'd2;
        end else if (b >= 8'h40 && b <= 8'h7E) begin
          if (b == 8'h4A && seq == 2'd1) clr_all = 1'b1;
          else state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (adv) begin
      row_n     = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
      eng_start = 1'b1;
      state_n   = S_CLR_ROW;
    end
    if (clr_all) begin
      col_n     = '0;
      row_n     = '0;
      eng_start = 1'b1;
      eng_all   = 1'b1;
      state_n   = S_CLR_ALL;
    end
  end

endmodule

// File: tb/tb_term_vram_writer.sv
// Directed bench for term_vram_writer; VRAM writes are logged
// on the falling edge and checked against hand-derived values.
module tb_term_vram_writer;
  import term_pkg::*;

  logic clk = 1'b0;
  logic rst;
  col_t cur_col;
  row_t cur_row;
  logic busy;

  term_vram_writer_if bus();

  term_vram_writer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [20:0] q[$];

  always @(negedge clk)
    if (bus.vram_we) q.push_back({bus.vram_addr, bus.vram_data});

  function automatic logic [12:0] ea(int r, int c);
    return 13'(r * 128 + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(n);
    if (!bus.in_ready) chk("send_timeout", 32'(n), 32'd0);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n, mark, bad;
    logic [7:0] seq_bytes [6];
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick(); tick(); tick();
    chk("rst_we", 32'(bus.vram_we), 32'd0);
    chk("rst_addr", 32'(bus.vram_addr), 32'd0);
    chk("rst_data", 32'(bus.vram_data), 32'h20);
    chk("rst_col", 32'(cur_col), 32'd0);
    chk("rst_row", 32'(cur_row), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    mark = q.size();
    rst = 1'b0;
    wait_ready(n);
    settle();
    chk("init_cycles", 32'(n), 32'd2400);
    chk("init_writes", 32'(q.size() - mark), 32'd2400);
    bad = 0;
    for (int i = 0; i < 2400 && mark + i < q.size(); i++)
      if (q[mark+i] !== {ea(i / 80, i % 80), 8'h20}) bad++;
    chk("init_sweep_bad", 32'(bad), 32'd0);
    chk("init_last", 32'(q[q.size()-1]), 32'({13'h0ECF, 8'h20}));
    chk("init_cursor", 32'({cur_row, cur_col}), 32'd0);

    send(8'h41);
    chk("A_we", 32'(bus.vram_we), 32'd1);
    chk("A_addr", 32'(bus.vram_addr), 32'h000);
    chk("A_data", 32'(bus.vram_data), 32'h41);
    chk("A_col", 32'(cur_col), 32'd1);
    send(CR);
    chk("cr_we", 32'(bus.vram_we), 32'd0);
    chk("cr_col", 32'(cur_col), 32'd0);

    mark = q.size();
    for (int i = 0; i < 80; i++) send(8'h42);
    chk("B_addr", 32'(bus.vram_addr), 32'h04F);
    chk("B_data", 32'(bus.vram_data), 32'h42);
    chk("B_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 7'd0}));
    chk("B_busy", 32'(busy), 32'd1);
    wait_ready(n);
    settle();
    bad = 0;
    for (int i = 0; i < 80 && mark + i < q.size(); i++)
      if (q[mark+i] !== {ea(0, i), 8'h42}) bad++;
    chk("B_row0_bad", 32'(bad), 32'd0);
    chk("B_wait", 32'(n), 32'd80);
    chk("B_writes", 32'(q.size() - mark), 32'd160);
    chk("clr1_first", 32'(q[mark+80]), 32'({13'h080, 8'h20}));
    chk("clr1_last", 32'(q[q.size()-1]), 32'({13'h0CF, 8'h20}));

    for (int i = 0; i < 28; i++) send(LF);
    chk("lf_row29", 32'(cur_row), 32'd29);
    send(LF);
    chk("wrap_row", 32'(cur_row), 32'd0);
    chk("wrap_we", 32'(bus.vram_we), 32'd0);
    mark = q.size();
    wait_ready(n);
    settle();
    chk("wrap_wait", 32'(n), 32'd80);
    chk("wrap_writes", 32'(q.size() - mark), 32'd80);
    chk("wrap_first", 32'(q[mark]), 32'({13'h000, 8'h20}));
    chk("wrap_last", 32'(q[q.size()-1]), 32'({13'h04F, 8'h20}));

    send(BS);
    chk("bs0_we", 32'(bus.vram_we), 32'd0);
    chk("bs0_col", 32'(cur_col), 32'd0);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
    send(BS);
    chk("bs5_we", 32'(bus.vram_we), 32'd1);
    chk("bs5_addr", 32'(bus.vram_addr), 32'h004);
    chk("bs5_data", 32'(bus.vram_data), 32'h20);
    chk("bs5_col", 32'(cur_col), 32'd4);

    send(TAB);
    chk("tab_8", 32'(cur_col), 32'd8);
    chk("tab_we", 32'(bus.vram_we), 32'd0);
    for (int i = 0; i < 8; i++) send(TAB);
    chk("tab_72", 32'(cur_col), 32'd72);
    send(TAB);
    chk("tab_clamp", 32'(cur_col), 32'd79);
    send(TAB);
    chk("tab_hold", 32'(cur_col), 32'd79);

    mark = q.size();
    send(8'h7F); send(8'h80); send(8'h01);
    settle();
    chk("ign_writes", 32'(q.size() - mark), 32'd0);
    chk("ign_cursor", 32'({cur_row, cur_col}), 32'({5'd0, 7'd79}));

    send(CR);
    seq_bytes[0] = 8'h1B; seq_bytes[1] = 8'h5B; seq_bytes[2] = 8'h33;
    seq_bytes[3] = 8'h31; seq_bytes[4] = 8'h6D; seq_bytes[5] = 8'h58;
    mark = q.size();
    for (int i = 0; i < 6; i++) send(seq_bytes[i]);
    settle();
`ifdef TERM_ESC_FILTER_EN
    chk("esc_writes", 32'(q.size() - mark), 32'd1);
    chk("esc_X", 32'(q[mark]), 32'({13'h000, 8'h58}));
    chk("esc_col", 32'(cur_col), 32'd1);
    mark = q.size();
    send(8'h1B); send(8'h5B); send(8'h33); send(8'h4A);
    chk("esc3J_busy", 32'(busy), 32'd0);
    chk("esc3J_col", 32'(cur_col), 32'd1);
    send(8'h1B); send(8'h5B); send(8'h32); send(8'h4A);
    chk("esc2J_busy", 32'(busy), 32'd1);
    chk("esc2J_col", 32'(cur_col), 32'd0);
    wait_ready(n);
    chk("esc2J_wait", 32'(n), 32'd2400);
`else
    chk("esc_writes", 32'(q.size() - mark), 32'd5);
    chk("esc_first", 32'(q[mark]), 32'({13'h000, 8'h5B}));
    chk("esc_last", 32'(q[q.size()-1]), 32'({13'h004, 8'h58}));
    chk("esc_col", 32'(cur_col), 32'd5);
`endif

    send(8'h5A);
    send(FF);
    chk("ff_busy", 32'(busy), 32'd1);
    chk("ff_ready", 32'(bus.in_ready), 32'd0);
    chk("ff_cursor", 32'({cur_row, cur_col}), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_we", 32'(bus.vram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    mark = q.size();
    wait_ready(n);
    settle();
    chk("restart_wait", 32'(n), 32'd2400);
    chk("restart_writes", 32'(q.size() - mark), 32'd2400);
    chk("restart_first", 32'(q[mark]), 32'({13'h000, 8'h20}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
